// File: rtl/mcp_pkg.sv
// Shared types and sizing helpers for the MCP bus sender.
package mcp_pkg;

   // Launch FSM: idle, enable-high window, enable-low spacing window.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // The counter must hold the largest reload value (count-1), so
   // sizing to max+1 leaves headroom and still works for 1-cycle windows.
   function automatic int cnt_w(input int hold, input int gap);
      return $clog2(max2(hold, gap) + 1);
   endfunction

endpackage

// File: rtl/mcp_pending_buf.sv
// Single-entry holding register. It parks one word that arrives while a
// transfer is already on the bus.
module mcp_pending_buf
   import mcp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;

   // A read empties the slot and a write fills it. The owner never
   // raises both in one cycle, because a write needs an empty slot and
   // a read needs a full one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else begin
         if (rd) begin
            valid_reg <= 1'b0;
         end
         if (wr) begin
            valid_reg <= 1'b1;
            data_reg  <= wr_data;
         end
      end
   end

   assign full = valid_reg;
   assign data = data_reg;

endmodule

// File: rtl/mcp_bus_sender.sv
// Source-domain launch stage of the MCP bus synchroniser. It holds the
// bus stable while the enable is high for HOLD_CYCLES. It then keeps the
// enable low for at least GAP_CYCLES. One extra word can be queued.
module mcp_bus_sender
   import mcp_pkg::*;
#(
   parameter int BUS_WIDTH   = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic [BUS_WIDTH-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic [BUS_WIDTH-1:0] o_unsync_bus,
   output logic                 o_bus_enable,
   output logic                 o_busy
);

   localparam int CW = cnt_w(HOLD_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

   state_t               state;
   logic [CW-1:0]        counter;
   logic [BUS_WIDTH-1:0] bus_reg;
   logic                 enable_reg;

   logic                 handshake;
   logic                 count_done;
   logic                 pend_wr;
   logic                 pend_rd;
   logic                 pend_full;
   logic [BUS_WIDTH-1:0] pend_data;

   assign handshake  = i_valid && o_ready;
   assign count_done = (counter == '0);

   // A word accepted while a window is running goes to the pending slot.
   // The exception is the last GAP cycle: that word goes straight onto
   // the bus, so the gap stays exactly GAP_CYCLES long.
   assign pend_wr = handshake &&
                    ((state == SEND) || ((state == GAP) && !count_done));
   assign pend_rd = (state == GAP) && count_done && pend_full;

   mcp_pending_buf #(
      .WIDTH (BUS_WIDTH)
   ) u_pending (
      .clk     (i_CLK),
      .rst     (i_RST),
      .wr      (pend_wr),
      .wr_data (i_data),
      .rd      (pend_rd),
      .full    (pend_full),
      .data    (pend_data)
   );

   // Launch FSM: it loads the bus and raises the enable together, then
   // times the high and low windows with one down-counter.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state      <= IDLE;
         counter    <= '0;
         bus_reg    <= '0;
         enable_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  bus_reg    <= i_data;
                  enable_reg <= 1'b1;
                  counter    <= HOLD_LOAD;
                  state      <= SEND;
               end
            end

            SEND: begin
               if (count_done) begin
                  enable_reg <= 1'b0;
                  counter    <= GAP_LOAD;
                  state      <= GAP;
               end else begin
                  counter <= counter - 1'b1;
               end
            end

            GAP: begin
               if (count_done) begin
                  if (pend_full) begin
                     // The queued word has priority; ready is low while the slot is full.
                     bus_reg    <= pend_data;
                     enable_reg <= 1'b1;
                     counter    <= HOLD_LOAD;
                     state      <= SEND;
                  end else if (handshake) begin
                     bus_reg    <= i_data;
                     enable_reg <= 1'b1;
                     counter    <= HOLD_LOAD;
                     state      <= SEND;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  counter <= counter - 1'b1;
               end
            end

            default: begin
               state      <= IDLE;
               counter    <= '0;
               enable_reg <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready      = !pend_full;
   assign o_unsync_bus = bus_reg;
   assign o_bus_enable = enable_reg;
   assign o_busy       = (state != IDLE) || pend_full;

endmodule

// File: tb/tb_mcp_bus_sender.sv
// Self-checking bench for mcp_bus_sender. A background monitor pops the
// scoreboard on every enable rise. It also checks the hold length, the
// gap length and bus stability. Directed tasks cover the corner cases.
// A second instance with 1-cycle windows checks full-rate toggling.
module tb_mcp_bus_sender;

   localparam int BW   = 8;
   localparam int HOLD = 4;
   localparam int GAP  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [BW-1:0] o_bus;
   logic          o_en;
   logic          o_busy;

   logic [BW-1:0] b_data = '0;
   logic          b_valid = 1'b0;
   logic          b_ready;
   logic [BW-1:0] b_bus;
   logic          b_en;
   logic          b_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [BW-1:0] q[$];
   logic [BW-1:0] q2[$];

   int  last_gap = 0;

   always #5 clk = ~clk;

   mcp_bus_sender #(.BUS_WIDTH(BW), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .i_CLK        (clk),
      .i_RST        (rst),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_unsync_bus (o_bus),
      .o_bus_enable (o_en),
      .o_busy       (o_busy)
   );

   mcp_bus_sender #(.BUS_WIDTH(BW), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
      .i_CLK        (clk),
      .i_RST        (rst),
      .i_data       (b_data),
      .i_valid      (b_valid),
      .o_ready      (b_ready),
      .o_unsync_bus (b_bus),
      .o_bus_enable (b_en),
      .o_busy       (b_busy)
   );

   // Background monitor for the main instance. It samples on the falling edge.
   initial begin
      logic          prev_en;
      logic [BW-1:0] prev_bus;
      logic [BW-1:0] exp;
      int            hi;
      int            lo;
      bit            first;
      prev_en = 1'b0; prev_bus = '0; hi = 0; lo = 0; first = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_en = 1'b0; prev_bus = '0; hi = 0; lo = 0; first = 1'b1;
            q.delete();
         end else begin
            if (o_en && !prev_en) begin
               if (!first) begin
                  n_checks++;
                  if (lo < GAP) begin
                     n_fail++;
                     $display("FAIL min_gap: low for %0d cycles, need >= %0d", lo, GAP);
                  end
               end
               last_gap = lo;
               first = 1'b0;
               hi = 1;
               n_checks++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL scoreboard: unexpected word %h on bus, nothing queued", o_bus);
               end else begin
                  exp = q.pop_front();
                  if (o_bus !== exp) begin
                     n_fail++;
                     $display("FAIL scoreboard: bus=%h expected %h", o_bus, exp);
                  end
               end
            end else if (o_en) begin
               hi++;
               n_checks++;
               if (o_bus !== prev_bus) begin
                  n_fail++;
                  $display("FAIL bus_stable_high: bus=%h was %h", o_bus, prev_bus);
               end
            end else begin
               if (prev_en) begin
                  n_checks++;
                  if (hi != HOLD) begin
                     n_fail++;
                     $display("FAIL hold_len: enable high %0d cycles, need %0d", hi, HOLD);
                  end
                  lo = 1;
               end else begin
                  lo++;
               end
               n_checks++;
               if (o_bus !== prev_bus) begin
                  n_fail++;
                  $display("FAIL bus_stable_low: bus=%h was %h", o_bus, prev_bus);
               end
            end
            prev_en = o_en;
            prev_bus = o_bus;
         end
      end
   end

   // Present one word starting at a falling edge and hold it until it is
   // accepted. Returns at the falling edge after the accepting edge, with
   // valid dropped.
   task automatic put(input logic [BW-1:0] d, output int waits);
      bit ok;
      ok = 1'b0;
      waits = 0;
      i_valid = 1'b1;
      i_data = d;
      for (int t = 0; t < 200; t++) begin
         if (o_ready) begin
            q.push_back(d);
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         waits++;
         @(negedge clk);
      end
      i_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL put_timeout: word %h not accepted, ready=%b", d, o_ready);
      end
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 300; t++) begin
         if (!o_busy && !o_en) break;
         @(negedge clk);
      end
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: busy=%b expected 0", name, o_busy);
      end
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_lost: %0d words never appeared, expected 0", name, q.size());
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({o_en, o_bus, o_ready, o_busy} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: en=%b bus=%h ready=%b busy=%b expected 0 00 1 0",
                  o_en, o_bus, o_ready, o_busy);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_single();
      int w;
      put(8'hA5, w);
      for (int k = 1; k <= 10; k++) begin
         n_checks++;
         if (o_en !== (k <= HOLD)) begin
            n_fail++;
            $display("FAIL single_en cycle %0d: en=%b expected %b", k, o_en, (k <= HOLD));
         end
         n_checks++;
         if (o_bus !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_bus cycle %0d: bus=%h expected a5", k, o_bus);
         end
         n_checks++;
         if (o_busy !== (k <= HOLD + GAP)) begin
            n_fail++;
            $display("FAIL single_busy cycle %0d: busy=%b expected %b", k, o_busy, (k <= HOLD + GAP));
         end
         @(negedge clk);
      end
      drain("single");
      $display("test_single done");
   endtask

   task automatic test_back_to_back();
      int w;
      put(8'h11, w);
      put(8'h22, w);
      n_checks++;
      if (w != 0) begin
         n_fail++;
         $display("FAIL b2b_accept_22: waited %0d cycles, expected 0 (accepted in SEND)", w);
      end
      put(8'h33, w);
      n_checks++;
      if (w != HOLD - 1 + GAP) begin
         n_fail++;
         $display("FAIL b2b_ready_low: 33 waited %0d cycles, expected %0d", w, HOLD - 1 + GAP);
      end
      #1;
      n_checks++;
      if (last_gap != GAP) begin
         n_fail++;
         $display("FAIL b2b_gap: gap before 22 was %0d, expected %0d", last_gap, GAP);
      end
      n_checks++;
      if (o_bus !== 8'h22) begin
         n_fail++;
         $display("FAIL b2b_bus: bus=%h expected 22 while 33 queued", o_bus);
      end
      @(negedge clk);
      drain("b2b");
      $display("test_back_to_back done");
   endtask

   task automatic test_gap_exit();
      int w;
      put(8'h3A, w);
      repeat (HOLD + GAP - 1) @(negedge clk);
      put(8'h5C, w);
      #1;
      n_checks++;
      if (w != 0) begin
         n_fail++;
         $display("FAIL gap_exit_accept: waited %0d, expected 0", w);
      end
      n_checks++;
      if (o_en !== 1'b1 || o_bus !== 8'h5C) begin
         n_fail++;
         $display("FAIL gap_exit_rise: en=%b bus=%h expected 1 5c", o_en, o_bus);
      end
      n_checks++;
      if (last_gap != GAP) begin
         n_fail++;
         $display("FAIL gap_exit_len: gap %0d expected exactly %0d", last_gap, GAP);
      end
      @(negedge clk);
      drain("gap_exit");
      $display("test_gap_exit done");
   endtask

   task automatic test_reset_mid();
      int w;
      int bad;
      put(8'h40, w);
      i_valid = 1'b1;
      i_data = 8'h77;
      @(negedge clk);
      i_valid = 1'b0;
      n_checks++;
      if (o_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_pending: ready=%b expected 0 with 77 queued", o_ready);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({o_en, o_bus, o_ready, o_busy} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rstmid_async: en=%b bus=%h ready=%b busy=%b expected 0 00 1 0",
                  o_en, o_bus, o_ready, o_busy);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         if (o_en !== 1'b0 || o_bus === 8'h77) bad++;
         @(negedge clk);
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rstmid_discard: %0d cycles showed enable or 77, expected 0", bad);
      end
      n_checks++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ready: ready=%b expected 1", o_ready);
      end
      put(8'h99, w);
      drain("rstmid");
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      int w;
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 6)) @(negedge clk);
         put(8'($urandom), w);
      end
      drain("random");
      $display("test_random done");
   endtask

   task automatic test_fast_toggle();
      int  sent;
      int  got;
      bit  started;
      logic prev;
      logic [BW-1:0] exp;
      sent = 0; got = 0; started = 1'b0; prev = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (started && got < 16) begin
            n_checks++;
            if (b_en === prev) begin
               n_fail++;
               $display("FAIL fast_toggle: en=%b same as previous cycle", b_en);
            end
         end
         if (b_en && !prev) begin
            started = 1'b1;
            n_checks++;
            if (q2.size() == 0) begin
               n_fail++;
               $display("FAIL fast_order: unexpected word %h", b_bus);
            end else begin
               exp = q2.pop_front();
               if (b_bus !== exp) begin
                  n_fail++;
                  $display("FAIL fast_order: bus=%h expected %h", b_bus, exp);
               end
            end
            got++;
         end
         prev = b_en;
         if (sent < 16) begin
            b_valid = 1'b1;
            b_data = 8'(sent);
            if (b_ready) begin
               q2.push_back(8'(sent));
               sent++;
            end
         end else begin
            b_valid = 1'b0;
         end
         if (got == 16 && !b_busy && !b_en) break;
         @(negedge clk);
      end
      b_valid = 1'b0;
      n_checks++;
      if (got != 16 || q2.size() != 0) begin
         n_fail++;
         $display("FAIL fast_count: got %0d words (%0d left), expected 16 (0 left)", got, q2.size());
      end
      $display("test_fast_toggle done");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_gap_exit();
      test_reset_mid();
      test_random();
      test_fast_toggle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
